// File: rtl/fetch_pkg.sv
// Shared LC-3b types for the fetch stage: word type, fetch FSM states, PC step helper.
package fetch_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } lc3b_fetch_state;

    localparam lc3b_word INSTR_BYTES = 16'd2;

    // Modulo-2^16 advance; 16'hFFFE wraps to 16'h0000.
    function automatic lc3b_word next_word(input lc3b_word a);
        return a + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read handshake, decode slot, and redirect input.
interface fetch_if;
    import fetch_pkg::*;

    logic     imem_read;
    lc3b_word imem_address;
    lc3b_word imem_rdata;
    logic     imem_resp;
    logic     stall;
    logic     redirect;
    lc3b_word redirect_pc;
    lc3b_word npc;
    lc3b_word ir;
    logic     valid;

    modport master (
        output imem_read, imem_address, npc, ir, valid,
        input  imem_rdata, imem_resp, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_read, imem_address, npc, ir, valid,
        output imem_rdata, imem_resp, stall, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch.sv
// LC-3b instruction fetch: PC, imem read handshake, npc/ir/valid slot toward decode.
// Latency: ir/valid load on the edge sampling imem_resp; one instr/cycle with a same-cycle memory.
// Backpressure: one-entry skid absorbs a response landing under stall, then reads pause until stall drops.
module fetch
    import fetch_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     reset_n,
    fetch_if.master  bus
);

    lc3b_fetch_state state_q, state_d;
    lc3b_word        pc_q, pc_d;
    lc3b_word        addr_q, addr_d;
    lc3b_word        ir_q, ir_d;
    lc3b_word        npc_q, npc_d;
    logic            valid_q, valid_d;
    lc3b_word        sk_ir_q, sk_ir_d;
    lc3b_word        sk_npc_q, sk_npc_d;
    logic            sk_valid_q, sk_valid_d;

    lc3b_word addr_inc;
    logic     consume;
    logic     slot_free;

    assign addr_inc  = next_word(addr_q);
    assign consume   = valid_q && !bus.stall;
    assign slot_free = !valid_q || consume;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            ir_q       <= '0;
            npc_q      <= '0;
            valid_q    <= 1'b0;
            sk_ir_q    <= '0;
            sk_npc_q   <= '0;
            sk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            npc_q      <= npc_d;
            valid_q    <= valid_d;
            sk_ir_q    <= sk_ir_d;
            sk_npc_q   <= sk_npc_d;
            sk_valid_q <= sk_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        npc_d      = npc_q;
        valid_d    = valid_q;
        sk_ir_d    = sk_ir_q;
        sk_npc_d   = sk_npc_q;
        sk_valid_d = sk_valid_q;

        if (bus.redirect) begin
            // Older-stage redirect overrides everything, including a concurrent stall.
            valid_d    = 1'b0;
            sk_valid_d = 1'b0;
            pc_d       = bus.redirect_pc;
            unique case (state_q)
                BUSY: begin
                    if (bus.imem_resp) begin
                        addr_d  = bus.redirect_pc;
                        state_d = BUSY;
                    end else begin
                        // The read in flight must still complete before the new target is requested.
                        state_d = FLUSH;
                    end
                end
                WAIT, IDLE: begin
                    addr_d  = bus.redirect_pc;
                    state_d = BUSY;
                end
                FLUSH: state_d = FLUSH;
                default: state_d = IDLE;
            endcase
        end else begin
            if (consume) begin
                valid_d = 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    addr_d  = pc_q;
                    state_d = BUSY;
                end
                BUSY: begin
                    if (bus.imem_resp) begin
                        if (slot_free) begin
                            ir_d    = bus.imem_rdata;
                            npc_d   = addr_inc;
                            valid_d = 1'b1;
                            pc_d    = addr_inc;
                            addr_d  = addr_inc;
                        end else begin
                            sk_ir_d    = bus.imem_rdata;
                            sk_npc_d   = addr_inc;
                            sk_valid_d = 1'b1;
                            pc_d       = addr_inc;
                            state_d    = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.stall) begin
                        ir_d       = sk_ir_q;
                        npc_d      = sk_npc_q;
                        valid_d    = sk_valid_q;
                        sk_valid_d = 1'b0;
                        addr_d     = pc_q;
                        state_d    = BUSY;
                    end
                end
                FLUSH: begin
                    if (bus.imem_resp) begin
                        addr_d  = pc_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.imem_read    = (state_q == BUSY) || (state_q == FLUSH);
    assign bus.imem_address = addr_q;
    assign bus.ir           = ir_q;
    assign bus.npc          = npc_q;
    assign bus.valid        = valid_q;

endmodule
